prog_loader: RTL



---
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader.sv | 88 ++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and main-memory write bus of the boot program loader
interface prog_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: framed stream (len, payload, checksum) into main memory, then CPU release
module prog_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    prog_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] sum;
    logic [ADDR_W-1:0] addr;
    logic              xfer;

    assign bus.in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
    assign xfer         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            len           <= '0;
            sum           <= '0;
            addr          <= '0;
            words_loaded  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE: if (start) state <= LEN;
                LEN: if (xfer) begin
                    if (bus.in_data == '0 || bus.in_data > MAX_LEN) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        len          <= bus.in_data[ADDR_W:0];
                        sum          <= '0;
                        addr         <= '0;
                        words_loaded <= '0;
                        state        <= DATA;
                    end
                end
                DATA: if (xfer) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= addr;
                    bus.mem_wdata <= bus.in_data;
                    sum           <= sum + bus.in_data;
                    addr          <= addr + 1'b1;
                    words_loaded  <= words_loaded + 1'b1;
                    // words_loaded still holds the count before this byte
                    if (words_loaded + 1'b1 == len) state <= CSUM;
                end
                CSUM: if (xfer) begin
                    if (bus.in_data == sum) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= ERR;
                        err   <= 1'b1;
                    end
                end
                DONE, ERR: if (start) begin
                    state    <= LEN;
                    cpu_hold <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
